// File: rtl/stage6_weighted_avg_if.sv
// Handshake and data bundle between stage5 and the stage6 weighted-average divider.
// Index i of c/cp carries weight c(i+1) and product cp(i+1).
interface stage6_weighted_avg_if #(
   parameter int unsigned DATA_W = 8
);
   logic [8:0][DATA_W-1:0]   c;
   logic [8:0][2*DATA_W-1:0] cp;
   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_W-1:0]        avg_out;
   logic                     div_zero;
   logic                     out_valid;
   logic                     out_ready;
   logic                     busy;

   modport master (
      output c, cp, in_valid, out_ready,
      input  in_ready, avg_out, div_zero, out_valid, busy
   );

   modport slave (
      input  c, cp, in_valid, out_ready,
      output in_ready, avg_out, div_zero, out_valid, busy
   );
endinterface

// File: rtl/stage6_weighted_avg.sv
// Final weighted-average stage: sums weights and products, then divides with a
// radix-2 restoring divider (one quotient bit per cycle) and hands the result out.
module stage6_weighted_avg #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ROUND  = 0
) (
   input logic                  clk,
   input logic                  rst,
   stage6_weighted_avg_if.slave bus
);

   localparam int unsigned SC_W  = DATA_W + 4;
   localparam int unsigned QW    = 2 * DATA_W + 4;
   localparam int unsigned RW    = DATA_W + 5;
   localparam int unsigned RW1   = RW + 1;
   localparam int unsigned CNT_W = $clog2(QW);
   localparam logic [CNT_W-1:0] LastIter = CNT_W'(QW - 1);

   typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

   state_e              state_q, state_d;
   logic [SC_W-1:0]     divisor_q, divisor_d;
   logic [QW-1:0]       quot_q, quot_d;
   logic [RW-1:0]       rem_q, rem_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   avg_q, avg_d;
   logic                div_zero_q, div_zero_d;

   logic [SC_W-1:0]     sum_c;
   logic [QW-1:0]       sum_cp;
   logic [QW-1:0]       dividend_in;
   logic [RW-1:0]       rem_shift;
   logic [RW1-1:0]      trial;
   logic                q_bit;
   logic [QW-1:0]       quot_next;
   logic [DATA_W-1:0]   quot_sat;

   always_comb begin
      sum_c  = '0;
      sum_cp = '0;
      for (int i = 0; i < 9; i++) begin
         sum_c  = sum_c + SC_W'(bus.c[i]);
         sum_cp = sum_cp + QW'(bus.cp[i]);
      end
      dividend_in = sum_cp + ((ROUND != 0) ? QW'(sum_c >> 1) : '0);
   end

   // Quotient bits shift into the LSB end of the dividend register as it empties.
   always_comb begin
      rem_shift = {rem_q[RW-2:0], quot_q[QW-1]};
      trial     = {1'b0, rem_shift} - RW1'(divisor_q);
      q_bit     = ~trial[RW];
      quot_next = {quot_q[QW-2:0], q_bit};
      quot_sat  = (|quot_next[QW-1:DATA_W]) ? '1 : quot_next[DATA_W-1:0];
   end

   always_comb begin
      state_d    = state_q;
      divisor_d  = divisor_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      avg_d      = avg_q;
      div_zero_d = div_zero_q;
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               divisor_d = sum_c;
               quot_d    = dividend_in;
               rem_d     = '0;
               cnt_d     = '0;
               if (sum_c == '0) begin
                  state_d    = StDone;
                  avg_d      = '0;
                  div_zero_d = 1'b1;
               end else begin
                  state_d = StDiv;
               end
            end
         end
         StDiv: begin
            rem_d  = q_bit ? trial[RW-1:0] : rem_shift;
            quot_d = quot_next;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LastIter) begin
               state_d    = StDone;
               avg_d      = quot_sat;
               div_zero_d = 1'b0;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         divisor_q  <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         avg_q      <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         divisor_q  <= divisor_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         avg_q      <= avg_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.busy      = (state_q != StIdle);
   assign bus.avg_out   = avg_q;
   assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_stage6_weighted_avg.sv
// Bench for stage6_weighted_avg: truncating and rounding instances share stimulus and are
// checked against an arithmetic reference model (directed cases plus random sets).
module tb_stage6_weighted_avg;

   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stage6_weighted_avg_if #(.DATA_W(DW)) bus0 ();
   stage6_weighted_avg_if #(.DATA_W(DW)) bus1 ();

   stage6_weighted_avg #(.DATA_W(DW), .ROUND(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   stage6_weighted_avg #(.DATA_W(DW), .ROUND(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cw [9];
   int unsigned cpw[9];
   int unsigned exp_avg0, exp_avg1, exp_dz, exp_lat;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Reference: plain integer division of the weighted sums.
   task automatic model();
      int unsigned sc  = 0;
      int unsigned scp = 0;
      for (int i = 0; i < 9; i++) begin
         sc  += cw[i];
         scp += cpw[i];
      end
      if (sc == 0) begin
         exp_dz   = 1;
         exp_avg0 = 0;
         exp_avg1 = 0;
         exp_lat  = 0;
      end else begin
         exp_dz   = 0;
         exp_avg0 = scp / sc;
         exp_avg1 = (scp + sc / 2) / sc;
         if (exp_avg0 > 255) exp_avg0 = 255;
         if (exp_avg1 > 255) exp_avg1 = 255;
         exp_lat  = 20;
      end
   endtask

   task automatic drive_set();
      for (int i = 0; i < 9; i++) begin
         bus0.c[i]  = cw[i][DW-1:0];
         bus1.c[i]  = cw[i][DW-1:0];
         bus0.cp[i] = cpw[i][2*DW-1:0];
         bus1.cp[i] = cpw[i][2*DW-1:0];
      end
      bus0.in_valid = 1'b1;
      bus1.in_valid = 1'b1;
   endtask

   task automatic drive_garbage();
      logic r;
      for (int i = 0; i < 9; i++) begin
         bus0.c[i]  = DW'($urandom);
         bus1.c[i]  = bus0.c[i];
         bus0.cp[i] = (2*DW)'($urandom);
         bus1.cp[i] = bus0.cp[i];
      end
      r = 1'($urandom);
      bus0.in_valid  = 1'b1;
      bus1.in_valid  = 1'b1;
      bus0.out_ready = r;
      bus1.out_ready = r;
   endtask

   task automatic quiet_inputs();
      bus0.in_valid  = 1'b0;
      bus1.in_valid  = 1'b0;
      bus0.out_ready = 1'b0;
      bus1.out_ready = 1'b0;
   endtask

   task automatic check_idle(input string tag, input int unsigned a0, input int unsigned a1);
      check_eq({tag, ":in_ready"},  32'(bus0.in_ready),  1);
      check_eq({tag, ":out_valid"}, 32'(bus0.out_valid), 0);
      check_eq({tag, ":busy"},      32'(bus0.busy),      0);
      check_eq({tag, ":avg0"},      32'(bus0.avg_out),   a0);
      check_eq({tag, ":avg1"},      32'(bus1.avg_out),   a1);
   endtask

   // Entered and left at posedge+1 with both DUTs idle.
   task automatic run_txn(input string tag, input int unsigned hold);
      int unsigned lat;
      model();
      check_eq({tag, ":in_ready_pre"}, 32'(bus0.in_ready), 1);
      drive_set();
      @(posedge clk); #1;
      drive_garbage();
      lat = 0;
      while (!bus0.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      quiet_inputs();
      check_eq({tag, ":latency"},    lat,                  exp_lat);
      check_eq({tag, ":out_valid1"}, 32'(bus1.out_valid),  1);
      check_eq({tag, ":in_ready"},   32'(bus0.in_ready),   0);
      check_eq({tag, ":busy"},       32'(bus0.busy),       1);
      check_eq({tag, ":avg0"},       32'(bus0.avg_out),    exp_avg0);
      check_eq({tag, ":avg1"},       32'(bus1.avg_out),    exp_avg1);
      check_eq({tag, ":dz0"},        32'(bus0.div_zero),   exp_dz);
      check_eq({tag, ":dz1"},        32'(bus1.div_zero),   exp_dz);
      for (int h = 0; h < int'(hold); h++) begin
         @(posedge clk); #1;
         check_eq({tag, ":hold_valid"}, 32'(bus0.out_valid), 1);
         check_eq({tag, ":hold_ready"}, 32'(bus0.in_ready),  0);
         check_eq({tag, ":hold_avg"},   32'(bus0.avg_out),   exp_avg0);
         check_eq({tag, ":hold_dz"},    32'(bus0.div_zero),  exp_dz);
      end
      bus0.out_ready = 1'b1;
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      quiet_inputs();
      check_idle({tag, ":post"}, exp_avg0, exp_avg1);
   endtask

   task automatic load_test1();
      for (int i = 0; i < 9; i++) begin
         cw[i]  = 1;
         cpw[i] = 10 * (i + 1);
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 9; i++) begin
         bus0.c[i] = '0; bus1.c[i] = '0; bus0.cp[i] = '0; bus1.cp[i] = '0;
      end
      quiet_inputs();
      #3;
      check_idle("reset", 0, 0);
      check_eq("reset:dz", 32'(bus0.div_zero), 0);
      #9 rst = 1'b0;
      @(posedge clk); #1;

      load_test1();
      run_txn("t1", 0);

      for (int i = 0; i < 9; i++) begin cw[i] = 0; cpw[i] = 0; end
      run_txn("t2_zero", 0);

      for (int i = 0; i < 9; i++) begin cw[i] = 255; cpw[i] = 65025; end
      run_txn("t3_full", 0);

      for (int i = 0; i < 9; i++) begin cw[i] = 0; cpw[i] = 0; end
      cw[0] = 2; cpw[0] = 20; cw[1] = 1; cpw[1] = 12;
      run_txn("t4_round", 0);

      load_test1();
      run_txn("t5_stall", 5);

      for (int n = 0; n < 30; n++) begin
         int unsigned mode;
         mode = $urandom_range(0, 9);
         for (int i = 0; i < 9; i++) begin
            int unsigned p;
            p = $urandom_range(0, 255);
            if (mode == 0) begin
               cw[i]  = 0;
               cpw[i] = $urandom_range(0, 65535);
            end else if (mode == 1) begin
               cw[i]  = (i == 0) ? $urandom_range(1, 3) : 0;
               cpw[i] = $urandom_range(0, 65535);
            end else begin
               cw[i]  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
               cpw[i] = cw[i] * p;
            end
         end
         run_txn("rand", $urandom_range(0, 2));
      end

      // Reset mid-divide must clear the held result and abort the transaction.
      load_test1();
      run_txn("t6_pre", 0);
      drive_set();
      @(posedge clk); #1;
      quiet_inputs();
      repeat (7) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_idle("t6_rst", 0, 0);
      check_eq("t6_rst:dz", 32'(bus0.div_zero), 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check_idle("t6_after", 0, 0);
      run_txn("t6_again", 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
